// File: rtl/obs_sprite_fetch.sv
// +------------------------------------------------------------------------+
// | Module      : obs_sprite_fetch                                         |
// | Description : Streams one obstacle sprite in raster order with a       |
// |               valid/ready handshake. Optional horizontal mirroring is  |
// |               enabled by defining OBS_SPRITE_MIRROR_EN.                |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`default_nettype none

module obs_sprite_fetch #(
  parameter int SPR_W   = 8,
  parameter int SPR_H   = 8,
  parameter int NUM_SPR = 4,
  localparam int XW = ($clog2(SPR_W) > 1) ? $clog2(SPR_W) : 1,
  localparam int YW = ($clog2(SPR_H) > 1) ? $clog2(SPR_H) : 1,
  localparam int SW = ($clog2(NUM_SPR) > 1) ? $clog2(NUM_SPR) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [SW-1:0] i_sprite_sel,
`ifdef OBS_SPRITE_MIRROR_EN
  input  logic          i_mirror,
`endif
  input  logic          i_ready,
  output logic          o_valid,
  output logic          o_pixel,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_last,
  output logic          o_busy,
  output logic          o_done
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t        r_state;
  logic [SW-1:0] r_sel;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_valid;
  logic          r_pixel;
  logic          r_last;
  logic          r_busy;
  logic          r_done;

  logic          w_mir_in;
  logic          w_mir_cur;
  logic          w_x_end;
  logic [XW-1:0] w_nx;
  logic [YW-1:0] w_ny;
  logic          w_n_last;
  logic          w_pix_first;
  logic          w_pix_next;

  // Sprite ROM: sel[1:0] picks the shape, sel[2] inverts it; col is the
  // already-mirrored read column.
  function automatic logic f_pix(input int sel, input logic mir, input int x, input int y);
    int   col;
    logic p;
    col = mir ? (SPR_W - 1 - x) : x;
    p   = 1'b0;
    case (sel[1:0])
      2'd0: p = 1'b1;
      2'd1: p = (col == SPR_W / 2) || (col == SPR_W / 2 - 1) ||
                ((y == SPR_H / 2) && (col > 0) && (col < SPR_W - 1));
      2'd2: p = col[0] ^ y[0];
      default: p = (col == 0) || (y == 0) || (col == SPR_W - 1) || (y == SPR_H - 1);
    endcase
    return (sel < NUM_SPR) ? (p ^ sel[2]) : 1'b0;
  endfunction

`ifdef OBS_SPRITE_MIRROR_EN
  logic r_mir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mir <= 1'b0;
    end else if ((r_state == S_IDLE) && i_start) begin
      r_mir <= i_mirror;
    end
  end

  assign w_mir_in  = i_mirror;
  assign w_mir_cur = r_mir;
`else
  assign w_mir_in  = 1'b0;
  assign w_mir_cur = 1'b0;
`endif

  assign w_x_end     = (r_x == XW'(SPR_W - 1));
  assign w_nx        = w_x_end ? '0 : (r_x + XW'(1));
  assign w_ny        = w_x_end ? (r_y + YW'(1)) : r_y;
  assign w_n_last    = (w_nx == XW'(SPR_W - 1)) && (w_ny == YW'(SPR_H - 1));
  assign w_pix_first = f_pix(int'(i_sprite_sel), w_mir_in, 0, 0);
  assign w_pix_next  = f_pix(int'(r_sel), w_mir_cur, int'(w_nx), int'(w_ny));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_pixel <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_STREAM;
            r_sel   <= i_sprite_sel;
            r_x     <= '0;
            r_y     <= '0;
            r_valid <= 1'b1;
            r_pixel <= w_pix_first;
            r_last  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_STREAM: begin
          // Outputs only move on a transfer, so a stall holds them stable.
          if (i_ready) begin
            if (r_last) begin
              r_state <= S_IDLE;
              r_valid <= 1'b0;
              r_pixel <= 1'b0;
              r_last  <= 1'b0;
              r_x     <= '0;
              r_y     <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_x     <= w_nx;
              r_y     <= w_ny;
              r_pixel <= w_pix_next;
              r_last  <= w_n_last;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_valid = r_valid;
  assign o_pixel = r_pixel;
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_last  = r_last;
  assign o_busy  = r_busy;
  assign o_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_obs_sprite_fetch.sv
// +------------------------------------------------------------------------+
// | Module      : tb_obs_sprite_fetch                                      |
// | Description : Self-checking bench for obs_sprite_fetch (8x8 sprites).  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_obs_sprite_fetch;

`ifdef OBS_SPRITE_MIRROR_EN
  localparam int NSPR = 8;
`else
  localparam int NSPR = 4;
`endif
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int N  = W * H;
  localparam int XW = 3;
  localparam int YW = 3;
  localparam int SW = ($clog2(NSPR) > 1) ? $clog2(NSPR) : 1;

  typedef struct {
    int sel;
    bit mir;
    int x;
    int y;
    bit exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [SW-1:0] i_sprite_sel = '0;
  logic          i_mirror = 1'b0;
  logic          i_ready = 1'b0;
  logic          o_valid;
  logic          o_pixel;
  logic [XW-1:0] o_x;
  logic [YW-1:0] o_y;
  logic          o_last;
  logic          o_busy;
  logic          o_done;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic img [16][N];
  vec_t tbl[$];

  always #5 clk = ~clk;

  obs_sprite_fetch #(.SPR_W(W), .SPR_H(H), .NUM_SPR(NSPR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (i_start),
    .i_sprite_sel (i_sprite_sel),
`ifdef OBS_SPRITE_MIRROR_EN
    .i_mirror     (i_mirror),
`endif
    .i_ready      (i_ready),
    .o_valid      (o_valid),
    .o_pixel      (o_pixel),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_last       (o_last),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  // Reference picture, straight from the shape definitions.
  function automatic bit model(input int sel, input int x, input int y, input bit mir);
    int c;
    bit p;
    if (sel >= NSPR) return 1'b0;
    c = mir ? (W - 1 - x) : x;
    case (sel % 4)
      0: p = 1'b1;
      1: p = (c == W / 2) || (c == W / 2 - 1) || ((y == H / 2) && (c > 0) && (c < W - 1));
      2: p = ((c % 2) != (y % 2));
      default: p = (c == 0) || (y == 0) || (c == W - 1) || (y == H - 1);
    endcase
    return (sel >= 4) ? !p : p;
  endfunction

  function automatic logic [31:0] pack(input bit v, input bit p, input bit l, input bit b,
                                        input bit d, input int x, input int y);
    return {8'(y), 8'(x), 11'b0, v, p, l, b, d};
  endfunction

  function automatic logic [31:0] obs();
    return {8'(o_y), 8'(o_x), 11'b0, o_valid, o_pixel, o_last, o_busy, o_done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start(input int sel, input bit mir);
    i_start      = 1'b1;
    i_sprite_sel = SW'(sel);
    i_mirror     = mir;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Called one cycle after i_start was sampled. mode: 0 ready always,
  // 1 ready toggling from 1, 2 random ready.
  task automatic stream_body(input int sel, input int mode, input bit mir,
                             input int mid_at, input int mid_sel,
                             input bit chain, input int chain_sel);
    int k   = 0;
    int cyc = 0;
    bit rdy;
    while (k < N && cyc < 4000) begin
      check("pixel", obs(), pack(1'b1, model(sel, k % W, k / W, mir), k == N - 1, 1'b1, 1'b0,
                                 k % W, k / W));
      img[sel * 2 + int'(mir)][k] = o_pixel;
      case (mode)
        0: rdy = 1'b1;
        1: rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      i_ready = rdy;
      if (mid_at >= 0 && k == mid_at) begin
        i_start      = 1'b1;
        i_sprite_sel = SW'(mid_sel);
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
      if (rdy) k++;
      cyc++;
    end
    i_start = 1'b0;
    if (mode == 0) check("cycles_ready", cyc, 64);
    if (mode == 1) check("cycles_toggle", cyc, 127);
    check("done_cycle", {o_valid, o_busy, o_done}, 3'b001);
    i_ready = 1'b0;
    if (chain) begin
      start(chain_sel, 1'b0);
    end else begin
      @(negedge clk);
      check("done_pulse_end", {o_valid, o_busy, o_done}, 3'b000);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int sel;
    bit mir;
    int row4_c[8];
    int row0_c[8];
    row4_c = '{0, 1, 1, 1, 1, 1, 1, 0};
    row0_c = '{0, 0, 0, 1, 1, 0, 0, 0};
    for (int i = 0; i < 8; i++) begin
      tbl.push_back('{sel: 1, mir: 1'b0, x: i, y: 4, exp: row4_c[i][0]});
      tbl.push_back('{sel: 1, mir: 1'b0, x: i, y: 0, exp: row0_c[i][0]});
`ifdef OBS_SPRITE_MIRROR_EN
      tbl.push_back('{sel: 5, mir: 1'b1, x: i, y: 4, exp: (i == 0 || i == 7)});
`endif
    end
    tbl.push_back('{sel: 2, mir: 1'b0, x: 1, y: 0, exp: 1'b1});
    tbl.push_back('{sel: 2, mir: 1'b0, x: 1, y: 1, exp: 1'b0});
    tbl.push_back('{sel: 0, mir: 1'b0, x: 7, y: 7, exp: 1'b1});
    tbl.push_back('{sel: 3, mir: 1'b0, x: 3, y: 3, exp: 1'b0});

    repeat (2) @(negedge clk);
    check("reset_state", obs(), 32'h0);
    rst_n = 1'b1;

    // Solid block, full-rate
    start(0, 1'b0);
    stream_body(0, 0, 1'b0, -1, 0, 1'b0, 0);

    // Checker with ready toggling
    start(2, 1'b0);
    stream_body(2, 1, 1'b0, -1, 0, 1'b0, 0);

    // Cactus; mid-stream start ignored, start in done cycle chains frame
    start(1, 1'b0);
    stream_body(1, 0, 1'b0, 10, 3, 1'b1, 3);
    stream_body(3, 0, 1'b0, -1, 0, 1'b0, 0);

    // Reset in the middle of a stream
    start(3, 1'b0);
    i_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("pixel20", obs(), pack(1'b1, model(3, 4, 2, 1'b0), 1'b0, 1'b1, 1'b0, 4, 2));
    rst_n = 1'b0;
    #1;
    check("async_reset", obs(), 32'h0);
    i_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_hold_no_done", obs(), 32'h0);
    end
    rst_n = 1'b1;
    start(2, 1'b0);
    stream_body(2, 2, 1'b0, -1, 0, 1'b0, 0);

`ifdef OBS_SPRITE_MIRROR_EN
    start(5, 1'b1);
    stream_body(5, 0, 1'b1, -1, 0, 1'b0, 0);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      check($sformatf("table_s%0d_m%0d_x%0d_y%0d", tbl[i].sel, tbl[i].mir, tbl[i].x, tbl[i].y),
            32'(img[tbl[i].sel * 2 + int'(tbl[i].mir)][tbl[i].y * W + tbl[i].x]),
            32'(tbl[i].exp));
    end

    repeat (8) begin
      sel = int'($urandom_range(0, NSPR - 1));
`ifdef OBS_SPRITE_MIRROR_EN
      mir = 1'($urandom_range(0, 1));
`else
      mir = 1'b0;
`endif
      start(sel, mir);
      stream_body(sel, 2, mir, -1, 0, 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/obs_sprite_fetch.md
OBS_SPRITE_FETCH -- requirements
Module: obs_sprite_fetch

Interface
REQ-001 SHALL have parameter SPR_W, default 8: sprite width in pixels, range 2..64.
REQ-002 SHALL have parameter SPR_H, default 8: sprite height in pixels, range 2..64.
REQ-003 SHALL have parameter NUM_SPR, default 4: number of obstacle sprites, range 1..8.
REQ-004 SHALL have the following ports, one per line. XW = max(1,$clog2(SPR_W)), YW = max(1,$clog2(SPR_H)), SW = max(1,$clog2(NUM_SPR)).
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- i_start  input  1  request a sprite stream
- i_sprite_sel  input  SW  sprite index, sampled with i_start
- i_ready  input  1  downstream accepts the current pixel
- o_valid  output  1  o_pixel/o_x/o_y/o_last are valid
- o_pixel  output  1  sprite colour bit, 1 = opaque
- o_x  output  XW  column of the current pixel
- o_y  output  YW  row of the current pixel
- o_last  output  1  current pixel is the final pixel of the sprite
- o_busy  output  1  stream in progress
- o_done  output  1  one-cycle pulse after the last pixel is accepted

Function
REQ-005 SHALL implement FSM states IDLE and STREAM.
REQ-006 In IDLE, i_start=1 SHALL latch i_sprite_sel, set x=0 and y=0, and enter STREAM on the next edge.
REQ-007 The first pixel SHALL be presented with o_valid=1 in the cycle after i_start is sampled (latency 1).
REQ-008 In STREAM, o_valid SHALL be 1 in every cycle.
REQ-009 A pixel SHALL transfer on any edge where o_valid=1 and i_ready=1.
REQ-010 While i_ready=0, o_pixel/o_x/o_y/o_last SHALL hold stable.
REQ-011 Pixels SHALL be emitted in raster order: x increments first; at x=SPR_W-1, x wraps to 0 and y increments.
REQ-012 o_last SHALL be 1 exactly when x=SPR_W-1 and y=SPR_H-1.
REQ-013 When the o_last pixel transfers, the block SHALL return to IDLE and pulse o_done=1 for exactly one cycle.
REQ-014 i_start while in STREAM SHALL be ignored; it is not queued.
REQ-015 i_start in the o_done cycle (IDLE) SHALL be accepted normally, giving back-to-back streams with one idle cycle between them.
REQ-016 o_busy SHALL equal (state==STREAM).
REQ-017 Sprite contents SHALL be combinational from (sel,x,y), with hw=SPR_W/2 and hh=SPR_H/2:
- sel 0: pixel = 1 for all positions (solid block).
- sel 1: cactus; pixel = 1 if x==hw or x==hw-1, or (y==hh and x>0 and x<SPR_W-1).
- sel 2: checker; pixel = x[0]^y[0].
- sel 3: frame; pixel = 1 if x==0 or y==0 or x==SPR_W-1 or y==SPR_H-1.
- sel 4..7: inverse of sel 0..3.
REQ-018 A latched sel >= NUM_SPR SHALL stream all-zero (transparent) pixels with normal timing and o_last.
REQ-019 o_pixel SHALL be registered, with no combinational path from i_ready or i_start to any output.

Reset
REQ-020 rst_n=0 SHALL asynchronously force state=IDLE, o_valid=0, o_pixel=0, o_x=0, o_y=0, o_last=0, o_busy=0, o_done=0, and latched sel=0.
REQ-021 Reset asserted mid-stream SHALL abort the stream with no o_done pulse.
REQ-022 After rst_n deasserts, the block SHALL accept i_start on the first clock edge.

Configuration
REQ-023 Macro OBS_SPRITE_MIRROR_EN SHALL, when defined, add input i_mirror (1 bit), latched with i_start.
REQ-024 With OBS_SPRITE_MIRROR_EN defined and i_mirror latched 1, the ROM SHALL be read at column SPR_W-1-x.
REQ-025 With OBS_SPRITE_MIRROR_EN defined, o_x SHALL still report the unmirrored output column x.
REQ-026 Without OBS_SPRITE_MIRROR_EN, the i_mirror port SHALL not exist and behaviour SHALL equal i_mirror=0.

Verification (defaults 8x8x4)
REQ-027 Start sel=0, i_ready=1 -> o_valid high for 64 consecutive cycles, all o_pixel=1, o_last at (7,7), o_done one cycle later.
REQ-028 Start sel=2, i_ready toggling 1/0 -> 64 transfers over 127 cycles, outputs stable during stalls, pixel(1,0)=1, pixel(1,1)=0.
REQ-029 Start sel=1 -> row 4 = 0111_1110 (x=0..7), row 0 = 0001_1000.
REQ-030 Assert rst_n=0 at pixel 20 -> all outputs 0 immediately, no o_done; a new i_start after release streams from (0,0).
REQ-031 i_start pulsed mid-stream and again in the o_done cycle -> first ignored, second starts a new stream.
REQ-032 With OBS_SPRITE_MIRROR_EN, NUM_SPR=8, sel=5, i_mirror=1 -> row 4 = 1000_0001 and o_x counts 0..7.
